// File: rtl/rv_sram_bridge.sv
// -----------------------------------------------------------------------------
// rv_sram_bridge
//
// Connects the PicoRV32 native memory interface (valid/ready) to two
// single-port synchronous SRAM macros: instruction memory (imem, bank 0) and
// data memory (dmem, bank 1). Reads wait a configurable SRAM latency.
// Partial-word stores are done as read-modify-write. Full-word stores are
// written in one shot. Out-of-range accesses raise a sticky error flag. A
// loader port lets the UART loader write imem while the bridge is idle, and it
// takes priority over the CPU.
//
// Ports
//   clk, rst                 system clock, asynchronous active-high reset
//   mem_valid/instr/addr/    CPU request (byte address; wstrb==0 is a read)
//   wdata/wstrb
//   mem_ready, mem_rdata     one-cycle completion pulse, registered read data
//   ld_valid/addr/data       loader imem write request (word address)
//   ld_ready                 loader accept (bridge idle)
//   bus_err_clr, bus_err     clear input, sticky error flag
//   {i,d}mem_csb/web         macro chip select / write enable, active-low
//   {i,d}mem_addr/din        macro word address / write data
//   {i,d}mem_dout            macro read data
// -----------------------------------------------------------------------------
module rv_sram_bridge #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int SRAM_LATENCY  = 1,
    parameter int IMEM_WRITABLE = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    mem_valid,
    input  logic                    mem_instr,
    input  logic [31:0]             mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_ready,
    output logic [DATA_WIDTH-1:0]   mem_rdata,

    input  logic                    ld_valid,
    input  logic [ADDR_WIDTH-1:0]   ld_addr,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    output logic                    ld_ready,

    input  logic                    bus_err_clr,
    output logic                    bus_err,

    output logic                    imem_csb,
    output logic                    imem_web,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic [DATA_WIDTH-1:0]   imem_din,
    input  logic [DATA_WIDTH-1:0]   imem_dout,

    output logic                    dmem_csb,
    output logic                    dmem_web,
    output logic [ADDR_WIDTH-1:0]   dmem_addr,
    output logic [DATA_WIDTH-1:0]   dmem_din,
    input  logic [DATA_WIDTH-1:0]   dmem_dout
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int BB = $clog2(SW);
    localparam int CW = $clog2(SRAM_LATENCY + 1);

    localparam logic [CW-1:0] LAT     = CW'(SRAM_LATENCY);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RMW_WAIT,
        RESP
    } state_t;

    // One macro command; CMD_IDLE is the parked value outside issue cycles.
    typedef struct packed {
        logic                  csb;
        logic                  web;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] din;
    } sram_cmd_t;

    localparam sram_cmd_t CMD_IDLE = '{csb: 1'b1, web: 1'b1, addr: '0, din: '0};

    // -------------------------------------------------------------------------
    // Request decode (meaningful only in the IDLE decode cycle)
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] req_index;
    logic                  req_bank;
    logic                  req_oor;
    logic                  req_read;
    logic                  req_full;
    logic                  req_drop;

    assign req_index = mem_addr[ADDR_WIDTH+BB-1 -: ADDR_WIDTH];
    assign req_bank  = mem_addr[ADDR_WIDTH+BB];
    assign req_oor   = |(mem_addr >> (ADDR_WIDTH + BB + 1));
    assign req_read  = (mem_wstrb == '0);
    assign req_full  = &mem_wstrb;
    // Stores into imem are refused unless the build allows self-modifying code.
    assign req_drop  = !req_read && !req_bank && (IMEM_WRITABLE == 0);

    // mem_instr is informational and the byte offset is ignored by design.
    logic unused_ok;
    assign unused_ok = ^{mem_instr, mem_addr[BB-1:0]};

    // -------------------------------------------------------------------------
    // State and request holding registers
    // -------------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  bank_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q;

    logic                  load_req;
    logic                  err_set;
    sram_cmd_t             imem_cmd, dmem_cmd, cmd;

    // Data returned by the bank captured at decode time.
    logic [DATA_WIDTH-1:0] dout_sel;
    logic [DATA_WIDTH-1:0] merged;

    assign dout_sel = bank_q ? dmem_dout : imem_dout;

    always_comb begin
        merged = dout_sel;
        for (int i = 0; i < SW; i++) begin
            if (wstrb_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and macro command logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        load_req = 1'b0;
        err_set  = 1'b0;
        imem_cmd = CMD_IDLE;
        dmem_cmd = CMD_IDLE;
        cmd      = CMD_IDLE;

        // Reset must park the macros at once, even though state is already
        // IDLE and the CPU may still be presenting a request.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (ld_valid) begin
                        imem_cmd = '{csb: 1'b0, web: 1'b0, addr: ld_addr, din: ld_data};
                    end else if (mem_valid) begin
                        if (req_oor || req_drop) begin
                            err_set = 1'b1;
                            rdata_d = '0;
                            state_d = RESP;
                        end else begin
                            load_req = 1'b1;
                            // Reads and partial stores both start with a read.
                            cmd = '{csb:  1'b0,
                                    web:  !req_full,
                                    addr: req_index,
                                    din:  req_full ? mem_wdata : '0};
                            if (req_bank) begin
                                dmem_cmd = cmd;
                            end else begin
                                imem_cmd = cmd;
                            end
                            if (req_full) begin
                                state_d = RESP;
                            end else begin
                                cnt_d   = LAT;
                                state_d = req_read ? RD_WAIT : RMW_WAIT;
                            end
                        end
                    end
                end

                RD_WAIT: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        rdata_d = dout_sel;
                        state_d = RESP;
                    end
                end

                RMW_WAIT: begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        // Old word is on dout this cycle: merge and write back.
                        cmd = '{csb: 1'b0, web: 1'b0, addr: index_q, din: merged};
                        if (bank_q) begin
                            dmem_cmd = cmd;
                        end else begin
                            imem_cmd = cmd;
                        end
                        state_d = RESP;
                    end
                end

                RESP: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            index_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (load_req) begin
                bank_q  <= req_bank;
                index_q <= req_index;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
            end
            // A new error wins over a coincident clear.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus_err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem_ready = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign ld_ready  = (state_q == IDLE);
    assign bus_err   = err_q;

    assign imem_csb  = imem_cmd.csb;
    assign imem_web  = imem_cmd.web;
    assign imem_addr = imem_cmd.addr;
    assign imem_din  = imem_cmd.din;

    assign dmem_csb  = dmem_cmd.csb;
    assign dmem_web  = dmem_cmd.web;
    assign dmem_addr = dmem_cmd.addr;
    assign dmem_din  = dmem_cmd.din;

endmodule

// File: tb/tb_rv_sram_bridge.sv
// -----------------------------------------------------------------------------
// tb_rv_sram_bridge
//
// Two bridge instances share the CPU/loader stimulus: u_dut1 (SRAM_LATENCY=1)
// and u_dut3 (SRAM_LATENCY=3), each with its own reset and SRAM models. Only
// one instance is out of reset at a time. The SRAM models return data only in
// the cycle it is due and read zero otherwise.
// -----------------------------------------------------------------------------
module tb_rv_sram_bridge;

    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst1, rst3;
    logic          mem_valid, mem_instr;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          bus_err_clr;
    logic          preload;

    logic          mem_ready1, ld_ready1, bus_err1;
    logic [DW-1:0] mem_rdata1;
    logic          imem_csb1, imem_web1, dmem_csb1, dmem_web1;
    logic [AW-1:0] imem_addr1, dmem_addr1;
    logic [DW-1:0] imem_din1, dmem_din1, imem_dout1, dmem_dout1;

    logic          mem_ready3, ld_ready3, bus_err3;
    logic [DW-1:0] mem_rdata3;
    logic          imem_csb3, imem_web3, dmem_csb3, dmem_web3;
    logic [AW-1:0] imem_addr3, dmem_addr3;
    logic [DW-1:0] imem_din3, dmem_din3, imem_dout3, dmem_dout3;

    rv_sram_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_LATENCY(1), .IMEM_WRITABLE(0)) u_dut1 (
        .clk(clk), .rst(rst1),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready1), .mem_rdata(mem_rdata1),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready1),
        .bus_err_clr(bus_err_clr), .bus_err(bus_err1),
        .imem_csb(imem_csb1), .imem_web(imem_web1), .imem_addr(imem_addr1),
        .imem_din(imem_din1), .imem_dout(imem_dout1),
        .dmem_csb(dmem_csb1), .dmem_web(dmem_web1), .dmem_addr(dmem_addr1),
        .dmem_din(dmem_din1), .dmem_dout(dmem_dout1)
    );

    rv_sram_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SRAM_LATENCY(3), .IMEM_WRITABLE(0)) u_dut3 (
        .clk(clk), .rst(rst3),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready3), .mem_rdata(mem_rdata3),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready3),
        .bus_err_clr(bus_err_clr), .bus_err(bus_err3),
        .imem_csb(imem_csb3), .imem_web(imem_web3), .imem_addr(imem_addr3),
        .imem_din(imem_din3), .imem_dout(imem_dout3),
        .dmem_csb(dmem_csb3), .dmem_web(dmem_web3), .dmem_addr(dmem_addr3),
        .dmem_din(dmem_din3), .dmem_dout(dmem_dout3)
    );

    // -------------------------------------------------------------------------
    // SRAM models
    // -------------------------------------------------------------------------
    logic [DW-1:0] imem1 [32];
    logic [DW-1:0] dmem1 [32];
    logic [DW-1:0] imem3 [32];
    logic [DW-1:0] dmem3 [32];
    logic [DW-1:0] ip0, ip1, dp0, dp1;
    int            wr1, wr3;

    function automatic logic [DW-1:0] init_word(input bit bank, input int i);
        if (!bank && i == 0) return 32'h0000_0093;
        if (!bank && i == 1) return 32'h0000_0013;
        if (bank && i == 1)  return 32'hDEAD_BEEF;
        if (bank && i == 2)  return 32'hAABB_CCDD;
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) begin
                imem1[i] <= init_word(1'b0, i);
                dmem1[i] <= init_word(1'b1, i);
            end
            wr1 <= 0;
        end else begin
            if (!imem_csb1 && !imem_web1) imem1[imem_addr1] <= imem_din1;
            if (!dmem_csb1 && !dmem_web1) dmem1[dmem_addr1] <= dmem_din1;
            wr1 <= wr1 + int'(!imem_csb1 && !imem_web1) + int'(!dmem_csb1 && !dmem_web1);
        end
        imem_dout1 <= (!imem_csb1 && imem_web1) ? imem1[imem_addr1] : 32'h0;
        dmem_dout1 <= (!dmem_csb1 && dmem_web1) ? dmem1[dmem_addr1] : 32'h0;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) begin
                imem3[i] <= init_word(1'b0, i);
                dmem3[i] <= init_word(1'b1, i);
            end
            wr3 <= 0;
        end else begin
            if (!imem_csb3 && !imem_web3) imem3[imem_addr3] <= imem_din3;
            if (!dmem_csb3 && !dmem_web3) dmem3[dmem_addr3] <= dmem_din3;
            wr3 <= wr3 + int'(!imem_csb3 && !imem_web3) + int'(!dmem_csb3 && !dmem_web3);
        end
        ip0        <= (!imem_csb3 && imem_web3) ? imem3[imem_addr3] : 32'h0;
        dp0        <= (!dmem_csb3 && dmem_web3) ? dmem3[dmem_addr3] : 32'h0;
        ip1        <= ip0;
        dp1        <= dp0;
        imem_dout3 <= ip1;
        dmem_dout3 <= dp1;
    end

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          clr;    // pulse bus_err_clr before the request
        int          lat;    // cycles from decode to mem_ready
        logic [31:0] rdata;  // mem_rdata when ready
        bit          err;    // bus_err when ready
        bit          icsb;   // expected imem_csb in the decode cycle
        bit          dcsb;   // expected dmem_csb in the decode cycle
        bit          web;    // expected web of the selected macro
        logic [4:0]  maddr;  // expected word address of the selected macro
        int          nwr;    // macro writes caused by the request
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                                input bit c, input int l, input logic [31:0] r, input bit e,
                                input bit ic, input bit dc, input bit wb, input logic [4:0] ma,
                                input int nw);
        vec_t v;
        v.addr = a; v.wdata = w; v.wstrb = s; v.clr = c; v.lat = l; v.rdata = r;
        v.err = e; v.icsb = ic; v.dcsb = dc; v.web = wb; v.maddr = ma; v.nwr = nw;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        int w0;
        if (v.clr) begin
            bus_err_clr = 1'b1;
            @(negedge clk);
            bus_err_clr = 1'b0;
        end
        w0        = wr1;
        mem_valid = 1'b1;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        mem_wstrb = v.wstrb;
        #1;
        check($sformatf("v%0d_icsb", idx), 32'(imem_csb1), 32'(v.icsb));
        check($sformatf("v%0d_dcsb", idx), 32'(dmem_csb1), 32'(v.dcsb));
        if (!v.icsb || !v.dcsb) begin
            check($sformatf("v%0d_web", idx), 32'(v.icsb ? dmem_web1 : imem_web1), 32'(v.web));
            check($sformatf("v%0d_maddr", idx), 32'(v.icsb ? dmem_addr1 : imem_addr1), 32'(v.maddr));
            if (!v.web) begin
                check($sformatf("v%0d_din", idx), v.icsb ? dmem_din1 : imem_din1, v.wdata);
            end
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready1 && n < 20);
        check($sformatf("v%0d_lat", idx), n, v.lat);
        check($sformatf("v%0d_rdata", idx), mem_rdata1, v.rdata);
        check($sformatf("v%0d_err", idx), 32'(bus_err1), 32'(v.err));
        check($sformatf("v%0d_writes", idx), wr1 - w0, v.nwr);
        mem_valid = 1'b0;
        mem_wstrb = 4'b0;
        @(negedge clk);
        check($sformatf("v%0d_ready_pulse", idx), 32'(mem_ready1), 32'd0);
    endtask

    vec_t vecs [12];

    initial begin
        int n;

        vecs[0]  = mk(32'h84,  32'h0,        4'b0000, 0, 2, 32'hDEADBEEF, 0, 1, 0, 1, 5'd1, 0);
        vecs[1]  = mk(32'h88,  32'h11223344, 4'b0101, 0, 2, 32'hDEADBEEF, 0, 1, 0, 1, 5'd2, 1);
        vecs[2]  = mk(32'h88,  32'h0,        4'b0000, 0, 2, 32'hAA22CC44, 0, 1, 0, 1, 5'd2, 0);
        vecs[3]  = mk(32'h00,  32'h12345678, 4'b1111, 0, 1, 32'h00000000, 1, 1, 1, 1, 5'd0, 0);
        vecs[4]  = mk(32'h00,  32'h0,        4'b0000, 1, 2, 32'h00000093, 0, 0, 1, 1, 5'd0, 0);
        vecs[5]  = mk(32'h100, 32'h0,        4'b0000, 0, 1, 32'h00000000, 1, 1, 1, 1, 5'd0, 0);
        vecs[6]  = mk(32'h90,  32'h12345678, 4'b1111, 1, 1, 32'h00000000, 0, 1, 0, 0, 5'd4, 1);
        vecs[7]  = mk(32'h90,  32'h0,        4'b0000, 0, 2, 32'h12345678, 0, 1, 0, 1, 5'd4, 0);
        vecs[8]  = mk(32'h84,  32'hCAFEF00D, 4'b1000, 0, 2, 32'h12345678, 0, 1, 0, 1, 5'd1, 1);
        vecs[9]  = mk(32'h87,  32'h0,        4'b0000, 0, 2, 32'hCAADBEEF, 0, 1, 0, 1, 5'd1, 0);
        vecs[10] = mk(32'h04,  32'h0,        4'b0000, 0, 2, 32'h00000013, 0, 0, 1, 1, 5'd1, 0);
        vecs[11] = mk(32'h200, 32'h0,        4'b0011, 0, 1, 32'h00000000, 1, 1, 1, 1, 5'd0, 0);

        rst1 = 1'b1; rst3 = 1'b1; preload = 1'b1;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0; bus_err_clr = 1'b0;
        repeat (2) @(negedge clk);
        preload = 1'b0;

        // Requests presented during reset must not reach the macros.
        mem_valid = 1'b1; mem_addr = 32'h84;
        #1;
        check("rst_gate_dcsb", 32'(dmem_csb1), 32'd1);
        @(negedge clk);
        mem_valid = 1'b0;
        rst1 = 1'b0;
        #1;
        check("rst_ready", 32'(mem_ready1), 32'd0);
        check("rst_rdata", mem_rdata1, 32'h0);
        check("rst_err", 32'(bus_err1), 32'd0);
        check("rst_csb", 32'({imem_csb1, dmem_csb1}), 32'd3);
        check("rst_web", 32'({imem_web1, dmem_web1}), 32'd3);
        check("rst_addr", 32'({imem_addr1, dmem_addr1}), 32'd0);
        check("rst_din", imem_din1 | dmem_din1, 32'h0);
        check("rst_ld_ready", 32'(ld_ready1), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Set and clear in the same cycle: set wins.
        mem_valid = 1'b1; mem_addr = 32'h100; bus_err_clr = 1'b1;
        @(negedge clk);
        mem_valid = 1'b0; bus_err_clr = 1'b0;
        check("err_set_wins", 32'(bus_err1), 32'd1);
        @(negedge clk);
        bus_err_clr = 1'b1;
        @(negedge clk);
        bus_err_clr = 1'b0;
        check("err_cleared", 32'(bus_err1), 32'd0);

        // Loader and CPU together: loader write first, then the CPU read.
        ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'hFEEDC0DE;
        mem_valid = 1'b1; mem_addr = 32'h0C; mem_wstrb = 4'b0;
        #1;
        check("ld_ready_idle", 32'(ld_ready1), 32'd1);
        check("ld_icsb", 32'(imem_csb1), 32'd0);
        check("ld_iweb", 32'(imem_web1), 32'd0);
        check("ld_iaddr", 32'(imem_addr1), 32'd3);
        check("ld_idin", imem_din1, 32'hFEEDC0DE);
        check("ld_dcsb", 32'(dmem_csb1), 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        check("ld_cpu_icsb", 32'(imem_csb1), 32'd0);
        check("ld_cpu_iweb", 32'(imem_web1), 32'd1);
        check("ld_cpu_iaddr", 32'(imem_addr1), 32'd3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("ld_ready_busy", 32'(ld_ready1), 32'd0);
        end while (!mem_ready1 && n < 20);
        check("ld_cpu_lat", n, 2);
        check("ld_cpu_rdata", mem_rdata1, 32'hFEEDC0DE);
        mem_valid = 1'b0;
        @(negedge clk);

        // SRAM_LATENCY=3 instance: reset in the middle of a read-modify-write.
        rst1 = 1'b1;
        rst3 = 1'b0;
        @(negedge clk);
        check("l3_rst_rdata", mem_rdata3, 32'h0);
        mem_valid = 1'b1; mem_addr = 32'h88; mem_wdata = 32'h11223344; mem_wstrb = 4'b0101;
        #1;
        check("l3_rmw_dcsb", 32'(dmem_csb3), 32'd0);
        check("l3_rmw_dweb", 32'(dmem_web3), 32'd1);
        check("l3_rmw_daddr", 32'(dmem_addr3), 32'd2);
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        #1;
        check("l3_abort_dcsb", 32'(dmem_csb3), 32'd1);
        check("l3_abort_dweb", 32'(dmem_web3), 32'd1);
        check("l3_abort_daddr", 32'(dmem_addr3), 32'd0);
        check("l3_abort_ddin", dmem_din3, 32'h0);
        check("l3_abort_ready", 32'(mem_ready3), 32'd0);
        mem_valid = 1'b0; mem_wstrb = 4'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("l3_abort_hold%0d", i), 32'({mem_ready3, dmem_csb3}), 32'd1);
        end
        check("l3_abort_writes", wr3, 0);
        check("l3_abort_mem", dmem3[2], 32'hAABBCCDD);
        rst3 = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h84;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_ready3 && n < 20);
        check("l3_read_lat", n, 4);
        check("l3_read_rdata", mem_rdata3, 32'hDEADBEEF);
        mem_valid = 1'b0;
        @(negedge clk);
        check("l3_ready_pulse", 32'(mem_ready3), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rv_sram_bridge.md
Name: rv_sram_bridge

Overview:
- Bridges the PicoRV32 native memory interface (valid/ready) to two single-port synchronous SRAM macros: instruction memory (imem) and data memory (dmem).
- Supersedes the hard-wired always-ready glue with a real handshake, a configurable SRAM read latency, and byte-strobe writes done as read-modify-write.
- Adds an out-of-range error flag and a loader port through which the UART loader writes imem.
- Sits between the CPU core and both SRAM macros at top level.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8. Strobe width SW = DATA_WIDTH/8. Localparam BB = log2(SW).
- ADDR_WIDTH, 5, word-address width of each SRAM macro port.
- SRAM_LATENCY, 1, cycles from a read-issue edge to valid dout; must be >= 1.
- IMEM_WRITABLE, 0, 1 lets CPU stores write imem; 0 drops them and flags an error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  CPU request valid
- mem_instr  in  1  instruction fetch (informational only; decode is by address)
- mem_addr  in  32  CPU byte address
- mem_wdata  in  DATA_WIDTH  store data
- mem_wstrb  in  SW  byte strobes; all zero means read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_WIDTH  read data, valid while mem_ready=1
- ld_valid  in  1  loader write request
- ld_addr  in  ADDR_WIDTH  loader imem word address
- ld_data  in  DATA_WIDTH  loader write data
- ld_ready  out  1  loader accept
- bus_err_clr  in  1  clears bus_err
- bus_err  out  1  sticky error flag
- imem_csb, dmem_csb  out  1  chip select, active-low
- imem_web, dmem_web  out  1  write enable, active-low
- imem_addr, dmem_addr  out  ADDR_WIDTH  macro word address
- imem_din, dmem_din  out  DATA_WIDTH  macro write data
- imem_dout, dmem_dout  in  DATA_WIDTH  macro read data

Behaviour:
- Address decode:
  - word index = mem_addr[ADDR_WIDTH+BB-1:BB]
  - bank = mem_addr[ADDR_WIDTH+BB]: 0 selects imem, 1 selects dmem
  - out of range = any bit of mem_addr[31:ADDR_WIDTH+BB+1] set
  - mem_addr[BB-1:0] is ignored
- Reset values:
  - state IDLE
  - csb=1, web=1, addr=0, din=0 on both macros
  - mem_ready=0, mem_rdata=0, bus_err=0
- Asynchronous reset mid-transaction abandons it: no ready pulse, no pending write is issued, macro controls deassert immediately.
- Macro controls are driven only in issue cycles. In all other cycles csb=1 and web=1.
- States are IDLE, RD_WAIT, RMW_WAIT and RESP. Let T be the IDLE cycle in which a request is decoded.
- IDLE, loader request:
  - ld_ready = (state==IDLE), combinational.
  - ld_valid has priority over the CPU. In cycle T it issues an imem write (imem_csb=0, imem_web=0, addr=ld_addr, din=ld_data) and stays in IDLE.
  - A pending CPU request waits; mem_valid remains held by the CPU.
- IDLE, CPU request (mem_valid=1, no ld_valid):
  - Out of range: no macro access; set bus_err; mem_rdata<=0; go to RESP (ready at T+1).
  - Store to imem with IMEM_WRITABLE=0: handled the same way as out of range.
  - Read (mem_wstrb=0): issue read; counter<=SRAM_LATENCY; go to RD_WAIT.
  - Full-word store (all strobes set): issue write of mem_wdata; go to RESP (ready at T+1).
  - Partial store: issue read; counter<=SRAM_LATENCY; go to RMW_WAIT.
- RD_WAIT: decrement the counter each cycle. On the cycle it reaches 0, capture the selected dout into mem_rdata and go to RESP. mem_ready rises at T+SRAM_LATENCY+1.
- RMW_WAIT:
  - Same count. On the final cycle, merge: byte i = mem_wstrb[i] ? mem_wdata byte i : dout byte i.
  - Issue the merged write in that same cycle, to the same bank and address, and go to RESP.
  - mem_ready rises at T+SRAM_LATENCY+1. mem_rdata is unchanged.
- RESP: mem_ready=1 for exactly one cycle, then return to IDLE. A new request is accepted from the following cycle.
- mem_rdata is registered and holds its value until the next read capture or out-of-range response.
- bus_err:
  - set by out-of-range requests and dropped imem stores
  - cleared by bus_err_clr
  - set wins when set and clear coincide
- mem_wdata, mem_wstrb and mem_addr are sampled only in cycle T. The CPU holds them stable until ready, but the bridge does not rely on it.

Test Plan:
- Reset, then read byte addr 0x84 (dmem word 1, preloaded 0xDEADBEEF) with SRAM_LATENCY=1 -> dmem_csb=0, web=1, addr=1 at T; mem_ready at T+2; mem_rdata=0xDEADBEEF.
- Store 0x11223344 to 0x88 with strobe 4'b0101 over 0xAABBCCDD -> one read then one write to dmem addr 2; final word 0xAA22CC44; mem_ready at T+2.
- Full store 0x12345678 to 0x00 with IMEM_WRITABLE=0 -> no imem write, bus_err=1, mem_ready at T+1; then pulse bus_err_clr -> bus_err=0.
- Read 0x100 (out of range) -> mem_ready at T+1, mem_rdata=0, bus_err=1, both csb held at 1.
- ld_valid and mem_valid asserted together in IDLE -> loader write to imem first; CPU read of the same word follows and returns the loaded data.
- SRAM_LATENCY=3, assert rst during RMW_WAIT -> no write issued, mem_ready stays 0, outputs at reset values; a subsequent read completes normally with ready at T+4.
